// File: rtl/instr_mem_pkg.sv
// Shared types for the instruction-memory responder: response entries, grant FSM states, latency bound.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package instr_mem_pkg;

  // Upper bound on both grant and response latency.
  localparam int unsigned MaxLatencyBound = 5;
  // Wide enough to hold any grant wait count up to MaxLatencyBound.
  localparam int unsigned WaitCntW = 3;

  typedef struct packed {
    logic        valid;
    logic [29:0] word_addr;
    logic        err;
  } rsp_entry_t;

  typedef enum logic {
    GntIdle,
    GntWait
  } gnt_state_e;

  // Read data for a word: error responses return zero, otherwise the address is scrambled with the seed.
  function automatic logic [31:0] fetch_data(input logic [29:0] word_addr,
                                             input logic        err,
                                             input logic [31:0] seed);
    return err ? 32'h0 : ({word_addr, 2'b00} ^ seed);
  endfunction

endpackage

// File: rtl/instr_mem_rsp_pipe.sv
// Response delay line: carries granted entries from the grant cycle towards the output registers.
// Latency: an entry on in_ent appears on feed_ent Depth-1 cycles later; out_vld follows one cycle after that.
// Backpressure: none; one entry per cycle in, one per cycle out, never dropped.
module instr_mem_rsp_pipe
  import instr_mem_pkg::*;
#(
  parameter int unsigned Depth = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  rsp_entry_t in_ent,
  output rsp_entry_t feed_ent,
  output logic       out_vld
);

  // feed_ent is the entry about to enter the final stage; the final stage's payload
  // lives in the top's output data registers, so only its valid bit is kept here.
  if (Depth == 1) begin : g_direct
    assign feed_ent = in_ent;
  end else begin : g_line
    rsp_entry_t stage_q [Depth-1];

    // Shift entries one stage per cycle; reset discards everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < Depth - 1; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q[0] <= in_ent;
        for (int unsigned i = 1; i < Depth - 1; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign feed_ent = stage_q[Depth-2];
  end

  // Final stage valid bit drives rvalid directly from a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld <= 1'b0;
    end else begin
      out_vld <= feed_ent.valid;
    end
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: memory end of an req/gnt/rvalid/err fetch bus with bounded grant latency.
// Latency: gnt GntLatency cycles after req rises (unless stalled/full); rvalid exactly RspLatency cycles after gnt.
// Backpressure: grant withheld while gnt_stall_i is high or MaxOutstanding responses are pending; responses cannot stall.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int unsigned GntLatency     = 2,
  parameter int unsigned RspLatency     = 3,
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [31:0] ErrAddrBase    = 32'h0001_0000,
  parameter logic [31:0] DataSeed       = 32'hA5A5_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        gnt_stall_i,
  output logic [3:0]  outstanding_o
);

  if (GntLatency > MaxLatencyBound) begin : g_bad_gnt_latency
    $error("GntLatency must be in 0..%0d", MaxLatencyBound);
  end
  if (RspLatency == 0 || RspLatency > MaxLatencyBound) begin : g_bad_rsp_latency
    $error("RspLatency must be in 1..%0d", MaxLatencyBound);
  end
  if (MaxOutstanding == 0 || MaxOutstanding > 8) begin : g_bad_max_outstanding
    $error("MaxOutstanding must be in 1..8");
  end

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  // The load cycle in IDLE counts as the first latency cycle, so WAIT counts the remaining GntLatency-1.
  localparam logic [WaitCntW-1:0] WaitLoad =
      (GntLatency == 0) ? '0 : WaitCntW'(GntLatency - 1);

  gnt_state_e          state_q, state_d;
  logic [WaitCntW-1:0] wait_q, wait_d;
  logic [CntW-1:0]     outstanding_q;
  logic                accept_ok;
  logic [29:0]         word_addr;
  logic                addr_err;
  logic                unused_addr_lo;
  rsp_entry_t          in_ent, feed_ent;
  logic [31:0]         rdata_q;
  logic                err_q;

  assign word_addr      = instr_addr_i[31:2];
  assign unused_addr_lo = ^instr_addr_i[1:0];
  assign addr_err       = ({word_addr, 2'b00} >= ErrAddrBase);

  // A response leaving this cycle frees its slot, so a full responder can still grant on that cycle.
  assign accept_ok = !gnt_stall_i && ((outstanding_q < MaxCnt) || instr_rvalid_o);

  // Grant FSM: count down the grant latency, then grant once unblocked; a dropped req abandons the wait.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    instr_gnt_o = 1'b0;
    unique case (state_q)
      GntIdle: begin
        if (instr_req_i) begin
          if (GntLatency == 0) begin
            if (accept_ok) begin
              instr_gnt_o = rst_ni;
            end else begin
              state_d = GntWait;
              wait_d  = '0;
            end
          end else begin
            state_d = GntWait;
            wait_d  = WaitLoad;
          end
        end
      end
      GntWait: begin
        if (!instr_req_i) begin
          state_d = GntIdle;
        end else if (wait_q != '0) begin
          wait_d = wait_q - WaitCntW'(1);
        end else if (accept_ok) begin
          instr_gnt_o = rst_ni;
          state_d     = GntIdle;
        end
      end
      default: state_d = GntIdle;
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= GntIdle;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign in_ent = '{valid: instr_gnt_o, word_addr: word_addr, err: addr_err};

  instr_mem_rsp_pipe #(
    .Depth (RspLatency)
  ) u_rsp_pipe (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .in_ent   (in_ent),
    .feed_ent (feed_ent),
    .out_vld  (instr_rvalid_o)
  );

  // Output data registers load alongside rvalid and hold their value between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (feed_ent.valid) begin
      rdata_q <= fetch_data(feed_ent.word_addr, feed_ent.err, DataSeed);
      err_q   <= feed_ent.err;
    end
  end

  // Outstanding count: grant adds one, response removes one, both together cancel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else if (instr_gnt_o && !instr_rvalid_o) begin
      outstanding_q <= outstanding_q + CntOne;
    end else if (!instr_gnt_o && instr_rvalid_o) begin
      outstanding_q <= outstanding_q - CntOne;
    end
  end

  assign instr_rdata_o = rdata_q;
  assign instr_err_o   = err_q;
  assign outstanding_o = 4'(outstanding_q);

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: four instances with different latency/limit settings.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Each table row is one clock cycle on one instance; the other instances see idle inputs.
module tb_instr_mem_responder;

  typedef struct {
    int          dut;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  outs;
  } vec_t;

  logic        clk;
  logic        rst_n  [4];
  logic        req    [4];
  logic [31:0] addr   [4];
  logic        stall  [4];
  logic        gnt    [4];
  logic        rvalid [4];
  logic [31:0] rdata  [4];
  logic        err    [4];
  logic [3:0]  outs   [4];

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Defaults: GntLatency 2, RspLatency 3, MaxOutstanding 4.
  instr_mem_responder #(.GntLatency(2), .RspLatency(3), .MaxOutstanding(4)) u_dflt (
    .clk_i(clk), .rst_ni(rst_n[0]), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]),
    .instr_err_o(err[0]), .gnt_stall_i(stall[0]), .outstanding_o(outs[0]));

  instr_mem_responder #(.GntLatency(0), .RspLatency(1), .MaxOutstanding(4)) u_fast (
    .clk_i(clk), .rst_ni(rst_n[1]), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]),
    .instr_err_o(err[1]), .gnt_stall_i(stall[1]), .outstanding_o(outs[1]));

  instr_mem_responder #(.GntLatency(0), .RspLatency(5), .MaxOutstanding(2)) u_full (
    .clk_i(clk), .rst_ni(rst_n[2]), .instr_req_i(req[2]), .instr_addr_i(addr[2]),
    .instr_gnt_o(gnt[2]), .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]),
    .instr_err_o(err[2]), .gnt_stall_i(stall[2]), .outstanding_o(outs[2]));

  instr_mem_responder #(.GntLatency(0), .RspLatency(5), .MaxOutstanding(4)) u_rst (
    .clk_i(clk), .rst_ni(rst_n[3]), .instr_req_i(req[3]), .instr_addr_i(addr[3]),
    .instr_gnt_o(gnt[3]), .instr_rvalid_o(rvalid[3]), .instr_rdata_o(rdata[3]),
    .instr_err_o(err[3]), .gnt_stall_i(stall[3]), .outstanding_o(outs[3]));

  function automatic vec_t mk(input int d, input logic rq, input logic [31:0] a, input logic st,
                              input logic g, input logic rv, input logic [31:0] rd,
                              input logic e, input logic [3:0] o);
    vec_t v;
    v.dut = d; v.req = rq; v.addr = a; v.stall = st;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.err = e; v.outs = o;
    return v;
  endfunction

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, tag, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 4; d++) begin
      req[d]   = 1'b0;
      addr[d]  = 32'h0;
      stall[d] = 1'b0;
    end
  endtask

  task automatic check_all(input int d, input int tag, input logic g, input logic rv,
                           input logic [31:0] rd, input logic e, input logic [3:0] o);
    check("gnt", tag, 32'(gnt[d]), 32'(g));
    check("rvalid", tag, 32'(rvalid[d]), 32'(rv));
    check("rdata", tag, rdata[d], rd);
    check("err", tag, 32'(err[d]), 32'(e));
    check("outstanding", tag, 32'(outs[d]), 32'(o));
  endtask

  initial begin
    vec_t v;
    idle_all();
    for (int d = 0; d < 4; d++) rst_n[d] = 1'b0;

    // Defaults: single fetch of 0x100.
    tbl.push_back(mk(0, 1, 32'h100, 0, 0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h100, 0, 0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h100, 0, 1, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 1, 32'hA5A5_0100, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'hA5A5_0100, 0, 0));
    // Error boundary: first erroring address.
    tbl.push_back(mk(0, 1, 32'h0001_0000, 0, 0, 0, 32'hA5A5_0100, 0, 0));
    tbl.push_back(mk(0, 1, 32'h0001_0000, 0, 0, 0, 32'hA5A5_0100, 0, 0));
    tbl.push_back(mk(0, 1, 32'h0001_0000, 0, 1, 0, 32'hA5A5_0100, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'hA5A5_0100, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'hA5A5_0100, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 1, 32'h0, 1, 1));
    // Last non-erroring word.
    tbl.push_back(mk(0, 1, 32'h0000_FFFC, 0, 0, 0, 32'h0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h0000_FFFC, 0, 0, 0, 32'h0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h0000_FFFC, 0, 1, 0, 32'h0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 1, 32'hA5A5_FFFC, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'hA5A5_FFFC, 0, 0));
    // Stall high for 4 cycles while req held; grant on the first unstalled cycle.
    tbl.push_back(mk(0, 1, 32'h200, 1, 0, 0, 32'hA5A5_FFFC, 0, 0));
    tbl.push_back(mk(0, 1, 32'h200, 1, 0, 0, 32'hA5A5_FFFC, 0, 0));
    tbl.push_back(mk(0, 1, 32'h200, 1, 0, 0, 32'hA5A5_FFFC, 0, 0));
    tbl.push_back(mk(0, 1, 32'h200, 1, 0, 0, 32'hA5A5_FFFC, 0, 0));
    tbl.push_back(mk(0, 1, 32'h200, 0, 1, 0, 32'hA5A5_FFFC, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'hA5A5_FFFC, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'hA5A5_FFFC, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 1, 32'hA5A5_0200, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'hA5A5_0200, 0, 0));
    // req dropped before grant: no entry, no response.
    tbl.push_back(mk(0, 1, 32'h300, 0, 0, 0, 32'hA5A5_0200, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 32'hA5A5_0200, 0, 0));

    // GntLatency 0 / RspLatency 1: streaming grants and responses; low address bits ignored.
    tbl.push_back(mk(1, 1, 32'h00, 0, 1, 0, 32'h0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h04, 0, 1, 1, 32'hA5A5_0000, 0, 1));
    tbl.push_back(mk(1, 1, 32'h08, 0, 1, 1, 32'hA5A5_0004, 0, 1));
    tbl.push_back(mk(1, 1, 32'h0C, 0, 1, 1, 32'hA5A5_0008, 0, 1));
    tbl.push_back(mk(1, 1, 32'h10, 0, 1, 1, 32'hA5A5_000C, 0, 1));
    tbl.push_back(mk(1, 1, 32'h17, 0, 1, 1, 32'hA5A5_0010, 0, 1));
    tbl.push_back(mk(1, 0, 32'h0,  0, 0, 1, 32'hA5A5_0014, 0, 1));
    tbl.push_back(mk(1, 0, 32'h0,  0, 0, 0, 32'hA5A5_0014, 0, 0));

    // MaxOutstanding 2, RspLatency 5: full, then grant alongside the freeing response.
    tbl.push_back(mk(2, 1, 32'h00, 0, 1, 0, 32'h0, 0, 0));
    tbl.push_back(mk(2, 1, 32'h04, 0, 1, 0, 32'h0, 0, 1));
    tbl.push_back(mk(2, 1, 32'h08, 0, 0, 0, 32'h0, 0, 2));
    tbl.push_back(mk(2, 1, 32'h08, 0, 0, 0, 32'h0, 0, 2));
    tbl.push_back(mk(2, 1, 32'h08, 0, 0, 0, 32'h0, 0, 2));
    tbl.push_back(mk(2, 1, 32'h08, 0, 1, 1, 32'hA5A5_0000, 0, 2));
    tbl.push_back(mk(2, 1, 32'h0C, 0, 1, 1, 32'hA5A5_0004, 0, 2));
    tbl.push_back(mk(2, 0, 32'h0, 0, 0, 0, 32'hA5A5_0004, 0, 2));
    tbl.push_back(mk(2, 0, 32'h0, 0, 0, 0, 32'hA5A5_0004, 0, 2));
    tbl.push_back(mk(2, 0, 32'h0, 0, 0, 0, 32'hA5A5_0004, 0, 2));
    tbl.push_back(mk(2, 0, 32'h0, 0, 0, 1, 32'hA5A5_0008, 0, 2));
    tbl.push_back(mk(2, 0, 32'h0, 0, 0, 1, 32'hA5A5_000C, 0, 1));
    tbl.push_back(mk(2, 0, 32'h0, 0, 0, 0, 32'hA5A5_000C, 0, 0));

    // Reset values on every instance.
    @(negedge clk);
    for (int d = 0; d < 4; d++) check_all(d, 1000 + d, 0, 0, 32'h0, 0, 4'd0);
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) rst_n[d] = 1'b1;

    // Table: one row per cycle.
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      idle_all();
      req[v.dut]   = v.req;
      addr[v.dut]  = v.addr;
      stall[v.dut] = v.stall;
      @(negedge clk);
      check_all(v.dut, i, v.gnt, v.rvalid, v.rdata, v.err, v.outs);
      @(posedge clk); #1;
    end
    idle_all();

    // Reset mid-flight: three outstanding, one-cycle reset pulse, nothing comes back.
    for (int i = 0; i < 3; i++) begin
      req[3]  = 1'b1;
      addr[3] = 32'(i * 4);
      @(negedge clk);
      check("rst_seq_gnt", 2000 + i, 32'(gnt[3]), 32'd1);
      @(posedge clk); #1;
    end
    req[3] = 1'b0;
    @(negedge clk);
    check("rst_seq_outstanding", 2010, 32'(outs[3]), 32'd3);
    @(posedge clk); #1;
    rst_n[3] = 1'b0;
    req[3]   = 1'b1;
    @(negedge clk);
    check_all(3, 2020, 0, 0, 32'h0, 0, 4'd0);
    @(posedge clk); #1;
    rst_n[3] = 1'b1;
    req[3]   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_no_rvalid", 2030 + i, 32'(rvalid[3]), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("rst_outstanding", 2040, 32'(outs[3]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
